// File: rtl/inst_queue_pkg.sv
// Shared constants for the fetch/decode boundary: packet layout and queue sizing.
package inst_queue_pkg;

   localparam int unsigned FS2DS_LEN = 64;
   localparam int unsigned IQ_DEPTH  = 4;

   // Packet field offsets within {inst, pc}
   localparam int unsigned INST_MSB  = 63;
   localparam int unsigned INST_LSB  = 32;
   localparam int unsigned PC_MSB    = 31;
   localparam int unsigned PC_LSB    = 0;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: in-order circular buffer whose
// allowin to fetch depends on occupancy only; any flush empties it atomically.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH = IQ_DEPTH,
   parameter int unsigned W     = FS2DS_LEN
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     fs2ds_valid,
   input  logic [W-1:0]             fs2ds_bus,
   output logic                     ds_allowin,
   output logic                     iq2ds_valid,
   output logic [W-1:0]             iq2ds_bus,
   input  logic                     id_allowin,
   input  logic                     br_taken,
   input  logic                     wb_ex,
   input  logic                     ertn_flush,
   output logic [$clog2(DEPTH):0]   iq_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   logic flush;
   logic enq;
   logic deq;

   always_comb begin
      flush       = br_taken | wb_ex | ertn_flush;
      ds_allowin  = (count != CW'(DEPTH));
      // Head is younger than the redirecting instruction, so hide it in the flush cycle
      iq2ds_valid = (count != '0) & ~flush;
      enq         = fs2ds_valid & ds_allowin & ~flush;
      deq         = iq2ds_valid & id_allowin;
      iq2ds_bus   = mem[rd_ptr];
      iq_count    = count;
   end

   always_comb begin
      count_next = count;
      unique case ({enq, deq})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + AW'(1);
         if (deq) rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
      end
   end

   // Storage is intentionally not reset or cleared; count alone defines validity
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= fs2ds_bus;
   end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus randomized traffic checked
// every cycle against a queue-based reference model.
module tb_inst_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned W     = 64;

   logic          clk = 1'b0;
   logic          resetn;
   logic          fs2ds_valid;
   logic [W-1:0]  fs2ds_bus;
   logic          ds_allowin;
   logic          iq2ds_valid;
   logic [W-1:0]  iq2ds_bus;
   logic          id_allowin;
   logic          br_taken;
   logic          wb_ex;
   logic          ertn_flush;
   logic [2:0]    iq_count;

   int n_tests = 0;
   int n_fail  = 0;
   int n_enq   = 0;
   bit started = 1'b0;

   logic [W-1:0] model_q [$];

   inst_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .fs2ds_valid (fs2ds_valid),
      .fs2ds_bus   (fs2ds_bus),
      .ds_allowin  (ds_allowin),
      .iq2ds_valid (iq2ds_valid),
      .iq2ds_bus   (iq2ds_bus),
      .id_allowin  (id_allowin),
      .br_taken    (br_taken),
      .wb_ex       (wb_ex),
      .ertn_flush  (ertn_flush),
      .iq_count    (iq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outputs from occupancy, then apply this cycle's transfer
   always @(negedge clk) begin
      bit flush, enq, deq;
      flush = br_taken | wb_ex | ertn_flush;
      if (started) begin
         chk("m_allowin", W'(ds_allowin), W'(model_q.size() != DEPTH));
         chk("m_valid", W'(iq2ds_valid), W'(model_q.size() != 0 && !flush));
         chk("m_count", W'(iq_count), W'(model_q.size()));
         if (model_q.size() != 0 && !flush)
            chk("m_head", iq2ds_bus, model_q[0]);
      end
      if (!resetn) begin
         model_q.delete();
         started = 1'b1;
      end else if (flush) begin
         model_q.delete();
      end else begin
         enq = fs2ds_valid && model_q.size() != DEPTH;
         deq = model_q.size() != 0 && id_allowin;
         if (deq) void'(model_q.pop_front());
         if (enq) begin
            model_q.push_back(fs2ds_bus);
            n_enq++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] pc, input bit ida,
                        input bit br, input bit ex, input bit er);
      fs2ds_valid = v;
      fs2ds_bus   = {$urandom(), pc};
      id_allowin  = ida;
      br_taken    = br;
      wb_ex       = ex;
      ertn_flush  = er;
   endtask

   task automatic idle_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   task automatic drain();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (DEPTH + 1) step();
   endtask

   initial begin
      logic [31:0] pc_a;
      int cyc;
      resetn = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      resetn = 1'b1;
      #1;
      chk("rst_count", W'(iq_count), W'(0));
      chk("rst_valid", W'(iq2ds_valid), W'(0));
      chk("rst_allowin", W'(ds_allowin), W'(1));

      // Streaming three packets through with decode always ready
      drive(1'b1, 32'h1C000000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h1C000004, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("s_head0", W'(iq2ds_bus[31:0]), W'(32'h1C000000));
      chk("s_cnt0", W'(iq_count), W'(1));
      step();
      drive(1'b1, 32'h1C000008, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("s_head1", W'(iq2ds_bus[31:0]), W'(32'h1C000004));
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("s_head2", W'(iq2ds_bus[31:0]), W'(32'h1C000008));
      chk("s_cnt2", W'(iq_count), W'(1));
      step();
      #1;
      chk("s_empty", W'(iq_count), W'(0));

      // Fill under back-pressure, then release decode for one cycle
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1C000010 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h1C000020, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("f_count4", W'(iq_count), W'(4));
      chk("f_allowin0", W'(ds_allowin), W'(0));
      step();
      id_allowin = 1'b1;
      #1;
      chk("f_allowin_deq", W'(ds_allowin), W'(0));
      chk("f_head", W'(iq2ds_bus[31:0]), W'(32'h1C000010));
      step();
      id_allowin = 1'b0;
      #1;
      chk("f_allowin1", W'(ds_allowin), W'(1));
      chk("f_count3", W'(iq_count), W'(3));
      step();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("f_head1", W'(iq2ds_bus[31:0]), W'(32'h1C000014));
      repeat (5) step();
      #1;
      chk("f_drained", W'(iq_count), W'(0));

      // Branch redirect with two entries and an incoming wrong-path packet
      drive(1'b1, 32'h1C000040, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h1C000044, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h1C0000F0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      chk("b_valid_mask", W'(iq2ds_valid), W'(0));
      chk("b_count2", W'(iq_count), W'(2));
      step();
      drive(1'b1, 32'h1C000100, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("b_count0", W'(iq_count), W'(0));
      chk("b_valid0", W'(iq2ds_valid), W'(0));
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("b_valid1", W'(iq2ds_valid), W'(1));
      chk("b_head", W'(iq2ds_bus[31:0]), W'(32'h1C000100));
      chk("b_count1", W'(iq_count), W'(1));
      drain();

      // Exception and ertn together on a full queue
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h1C000200 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 32'h1C000300, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      chk("e_valid_mask", W'(iq2ds_valid), W'(0));
      chk("e_allowin_full", W'(ds_allowin), W'(0));
      step();
      idle_cycle();
      chk("e_count0", W'(iq_count), W'(0));
      chk("e_allowin1", W'(ds_allowin), W'(1));

      // Randomized traffic with occasional flushes
      cyc = 0;
      n_enq = 0;
      pc_a = 32'h1C001000;
      while (n_enq < 10000 && cyc < 60000) begin
         drive($urandom_range(0, 9) < 7, pc_a, $urandom_range(0, 9) < 7,
               $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0,
               $urandom_range(0, 199) == 0);
         pc_a = pc_a + 32'd4;
         step();
         cyc++;
      end
      n_tests++;
      if (n_enq < 10000) begin
         n_fail++;
         $display("FAIL rand_budget actual=%0d required=10000", n_enq);
      end
      drain();

      // Reset in the middle of operation with three entries held
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h1C000400 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("r_count3", W'(iq_count), W'(3));
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      #1;
      chk("r_count0", W'(iq_count), W'(0));
      chk("r_valid0", W'(iq2ds_valid), W'(0));
      chk("r_allowin1", W'(ds_allowin), W'(1));
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and the decode stage of the five-stage LoongArch pipeline. It accepts {inst, pc} packets from fetch, buffers up to DEPTH of them in order, and presents the oldest one to decode with a valid/allowin handshake. Its allowin back to fetch is a function of occupancy only, so decode back-pressure never reaches fetch or the instruction SRAM enable within the same cycle. Flush events empty the queue atomically: branch redirect from decode, exception or ertn from writeback.

## Interface
- DEPTH, 4: number of entries; power of two, minimum 2.
- W, `FS2DS_LEN (64): packet width; layout {inst[63:32], pc[31:0]}.
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- fs2ds_valid  in  1  fetch presents a packet.
- fs2ds_bus  in  W  packet from fetch.
- ds_allowin  out  1  to fetch: queue can accept a packet; registered-state function, equals count != DEPTH.
- iq2ds_valid  out  1  head packet valid to decode.
- iq2ds_bus  out  W  head packet, {inst, pc}.
- id_allowin  in  1  decode accepts the head this cycle.
- br_taken  in  1  branch redirect resolved in decode.
- wb_ex  in  1  exception flush from writeback.
- ertn_flush  in  1  ertn flush from writeback.
- iq_count  out  log2(DEPTH)+1  current occupancy.

## Operation
- flush = br_taken | wb_ex | ertn_flush.
- enq = fs2ds_valid & ds_allowin & ~flush.
- deq = iq2ds_valid & id_allowin.
- iq2ds_valid = (count != 0) & ~flush; the head is masked in the flush cycle because it is younger than the redirecting instruction.
- iq2ds_bus = mem[rd_ptr]. The value is don't-care when iq2ds_valid = 0.
- Storage: circular buffer mem[DEPTH], wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count register. No full/empty ambiguity, because count is authoritative.
- On enq: mem[wr_ptr] <= fs2ds_bus, wr_ptr++.
- On deq: rd_ptr++.
- count_next = count + enq - deq.
- Simultaneous enq and deq with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count = DEPTH): ds_allowin = 0 even if deq happens that cycle. There is no same-cycle pass-through of freed space.
- Empty (count = 0): no bypass. A packet enqueued in cycle N is first visible at the head in N+1.
- Flush: at the next edge, count <= 0 and wr_ptr <= rd_ptr <= 0. Any enqueue that cycle is dropped, because the fetch-stage instruction is wrong-path.
- Flush takes priority over enq and deq. Packet contents in mem are not cleared.
- Order is strict FIFO. Packets are never reordered, duplicated, or modified.

## Timing
- Reset (resetn = 0 at an edge):
  - count, wr_ptr and rd_ptr become 0.
  - After reset: ds_allowin = 1, iq2ds_valid = 0, iq_count = 0.
  - mem is not reset.
- Latency: fetch to decode is 1 cycle minimum. Throughput is 1 packet/cycle in steady state, with simultaneous enq and deq.
- Combinational paths:
  - ds_allowin depends on registers only.
  - iq2ds_valid depends on count and the flush inputs.
  - There is no path from id_allowin to ds_allowin.
- Flush in cycle N:
  - iq2ds_valid = 0 in cycle N.
  - The queue is empty in cycle N+1.
  - The first post-redirect packet that fetch delivers in N+1 is enqueued normally and is visible in N+2.
- Reset asserted mid-operation discards all contents, with the same result as a flush.
- br_taken and wb_ex in the same cycle: a single flush. Cause is irrelevant to this block.

## Structure
- Single flat module; no sub-module. A generic sync FIFO is not factored out because flush and head-masking are queue-specific.
- Shared header macro.h holds:
  - `FS2DS_LEN (64), already used by fetch.
  - New `IQ_DEPTH (4), used as the top-level DEPTH override.
  - Packet field offsets, `INST_MSB 63 and `PC_MSB 31, for decode consumers.

## Test plan
- Reset then 3 consecutive packets pc 0x1C000000/04/08 with id_allowin = 1 -> each is seen at the head one cycle after enqueue, in order; iq_count stays ≤ 1.
- id_allowin = 0 while 5 packets are offered -> 4 accepted; ds_allowin = 0 after the 4th; the 5th is held by fetch. id_allowin = 1 in one cycle -> ds_allowin stays 0 that cycle and is 1 the next; all 5 drain in order.
- Queue holds 2 packets and br_taken pulses while fs2ds_valid = 1 -> iq2ds_valid = 0 that cycle; iq_count = 0 next cycle; the incoming packet is dropped; the next packet 0x1C000100 appears 1 cycle after its enqueue.
- wb_ex and ertn_flush asserted together with a full queue -> a single flush; empty next cycle; ds_allowin = 1.
- Random valid/allowin streams of 10k packets with wrap-around -> a scoreboard matches every pc and inst exactly; no loss or duplication outside flush windows.
- resetn pulled low with count = 3 -> after reset, iq_count = 0, iq2ds_valid = 0, ds_allowin = 1.
